// File: rtl/oled_pkg.sv
// -----------------------------------------------------------------------------
// oled_pkg
//   Shared definitions for the OLED display path.
//   - SSD1306-style command byte constants (page addressing for the frame
//     streamer, power-up / orientation codes for the SPI serializer).
//   - State encoding of oled_frame_streamer.
// -----------------------------------------------------------------------------
package oled_pkg;

    // Page-addressing commands emitted ahead of every page.
    localparam logic [7:0] OLED_CMD_PAGE_BASE = 8'hB0;  // OR-ed with page number
    localparam logic [7:0] OLED_CMD_COL_LO    = 8'h00;  // column start, low nibble
    localparam logic [7:0] OLED_CMD_COL_HI    = 8'h10;  // column start, high nibble

    // Power-up / orientation codes used by the serializer's init sequence.
    localparam logic [7:0] OLED_CMD_DISPLAY_OFF = 8'hAE;
    localparam logic [7:0] OLED_CMD_DISPLAY_ON  = 8'hAF;
    localparam logic [7:0] OLED_CMD_CHARGE_PUMP = 8'h8D;
    localparam logic [7:0] OLED_CMD_PRECHARGE   = 8'hD9;
    localparam logic [7:0] OLED_CMD_SEG_REMAP   = 8'hA1;
    localparam logic [7:0] OLED_CMD_COM_SCAN    = 8'hC8;
    localparam logic [7:0] OLED_CMD_COM_PINS    = 8'hDA;

    // Frame streamer states.
    typedef enum logic [2:0] {
        ST_IDLE,    // no frame in progress
        ST_CMD,     // offering page command byte cmd_idx
        ST_FETCH,   // framebuffer read strobe
        ST_RDWAIT,  // read data arrives, captured into out_byte
        ST_DATA,    // offering one display data byte
        ST_GAP      // idle interval between auto-refreshed frames
    } stream_state_t;

endpackage

// File: rtl/oled_frame_streamer.sv
// -----------------------------------------------------------------------------
// oled_frame_streamer
//   Walks a PAGES x COLS monochrome framebuffer page by page and streams it to
//   the OLED SPI serializer over a valid/ready handshake. Each page is preceded
//   by three page-addressing command bytes (dc=0) followed by COLS data bytes
//   (dc=1). Each data byte costs FETCH, RDWAIT, DATA (3 cycles minimum).
//
//   Optional feature, macro OLED_FRAME_AUTO_REFRESH_EN:
//     defined   - after each frame wait REFRESH_GAP cycles in GAP, then start
//                 the next frame on its own.
//     undefined - every frame ends in IDLE; a new frame needs start.
//
// Ports
//   clock      in   system clock
//   reset      in   asynchronous active-high reset
//   start      in   request one frame (honoured in IDLE/GAP, not on done cycle)
//   abort      in   synchronous; drop the frame, back to IDLE, no done
//   fb_rd      out  framebuffer read strobe
//   fb_addr    out  read address, page*COLS + col (registered)
//   fb_data    in   read data, valid one cycle after fb_rd
//   out_valid  out  byte available to the serializer
//   out_ready  in   serializer accepts the byte
//   out_byte   out  byte to shift out
//   out_dc     out  0 = command, 1 = display data
//   busy       out  frame in progress
//   done       out  one-cycle pulse after the last data byte is accepted
// -----------------------------------------------------------------------------
module oled_frame_streamer
    import oled_pkg::*;
#(
    parameter int PAGES = 4,
    parameter int COLS  = 128,
`ifdef OLED_FRAME_AUTO_REFRESH_EN
    parameter int REFRESH_GAP = 50000,
`endif
    localparam int AW = $clog2(PAGES * COLS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    output logic          fb_rd,
    output logic [AW-1:0] fb_addr,
    input  logic [7:0]    fb_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_byte,
    output logic          out_dc,
    output logic          busy,
    output logic          done
);

    localparam int CW = $clog2(COLS);
    localparam int PW = $clog2(PAGES);

    localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
    localparam logic [PW-1:0] PAGE_LAST = PW'(PAGES - 1);

    stream_state_t state;
    logic [PW-1:0] page;
    logic [CW-1:0] col;
    logic [1:0]    cmd_idx;
`ifdef OLED_FRAME_AUTO_REFRESH_EN
    logic [31:0]   gap_cnt;
`endif

    logic xfer;
    assign xfer = out_valid & out_ready;

    // Page command byte selection: B0|page, then column low, then column high.
    function automatic logic [7:0] cmd_byte(input logic [1:0] idx, input logic [PW-1:0] p);
        // NOTE: every path returns a value; a case without default in
        // combinational code is how unintended latches get inferred.
        case (idx)
            2'd0:    return OLED_CMD_PAGE_BASE | 8'(p);
            2'd1:    return OLED_CMD_COL_LO;
            default: return OLED_CMD_COL_HI;
        endcase
    endfunction

    function automatic logic [AW-1:0] pix_addr(input logic [PW-1:0] p, input logic [CW-1:0] c);
        return AW'(p) * AW'(COLS) + AW'(c);
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            page      <= '0;
            col       <= '0;
            cmd_idx   <= '0;
            fb_rd     <= 1'b0;
            fb_addr   <= '0;
            out_valid <= 1'b0;
            out_byte  <= 8'h00;
            out_dc    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef OLED_FRAME_AUTO_REFRESH_EN
            gap_cnt   <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch below
            // reads the pre-edge values of state and counters.
            done <= 1'b0;

            if (abort) begin
                // Abort wins over start and over a transfer in the same cycle;
                // the byte on offer is simply withdrawn.
                state     <= ST_IDLE;
                out_valid <= 1'b0;
                fb_rd     <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        // A start coinciding with the done pulse is ignored.
                        if (start && !done) begin
                            state     <= ST_CMD;
                            page      <= '0;
                            col       <= '0;
                            cmd_idx   <= '0;
                            busy      <= 1'b1;
                            out_valid <= 1'b1;
                            out_dc    <= 1'b0;
                            out_byte  <= cmd_byte(2'd0, '0);
                        end
                    end

                    ST_CMD: begin
                        if (xfer) begin
                            if (cmd_idx != 2'd2) begin
                                cmd_idx  <= cmd_idx + 2'd1;
                                out_byte <= cmd_byte(cmd_idx + 2'd1, page);
                            end else begin
                                state     <= ST_FETCH;
                                out_valid <= 1'b0;
                                fb_rd     <= 1'b1;
                                fb_addr   <= pix_addr(page, col);
                            end
                        end
                    end

                    ST_FETCH: begin
                        fb_rd <= 1'b0;
                        state <= ST_RDWAIT;
                    end

                    ST_RDWAIT: begin
                        out_byte  <= fb_data;
                        out_dc    <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= ST_DATA;
                    end

                    ST_DATA: begin
                        if (xfer) begin
                            if (col != COL_LAST) begin
                                col       <= col + CW'(1);
                                state     <= ST_FETCH;
                                out_valid <= 1'b0;
                                fb_rd     <= 1'b1;
                                fb_addr   <= pix_addr(page, col + CW'(1));
                            end else if (page != PAGE_LAST) begin
                                page      <= page + PW'(1);
                                col       <= '0;
                                cmd_idx   <= '0;
                                state     <= ST_CMD;
                                out_dc    <= 1'b0;
                                out_byte  <= cmd_byte(2'd0, page + PW'(1));
                            end else begin
                                out_valid <= 1'b0;
                                busy      <= 1'b0;
                                done      <= 1'b1;
`ifdef OLED_FRAME_AUTO_REFRESH_EN
                                state     <= ST_GAP;
                                gap_cnt   <= '0;
`else
                                state     <= ST_IDLE;
`endif
                            end
                        end
                    end

`ifdef OLED_FRAME_AUTO_REFRESH_EN
                    ST_GAP: begin
                        // Leaves after REFRESH_GAP counted cycles, so the next
                        // B0 shows REFRESH_GAP+1 cycles after done.
                        if ((start && !done) || gap_cnt == 32'(REFRESH_GAP)) begin
                            state     <= ST_CMD;
                            page      <= '0;
                            col       <= '0;
                            cmd_idx   <= '0;
                            busy      <= 1'b1;
                            out_valid <= 1'b1;
                            out_dc    <= 1'b0;
                            out_byte  <= cmd_byte(2'd0, '0);
                        end else begin
                            gap_cnt <= gap_cnt + 32'd1;
                        end
                    end
`endif

                    default: begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        fb_rd     <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
